lsu_unit: RTL and testbench

Multi-cycle load/store stage sitting between EXU and the write-back stage.
- Accepts one instruction per EXU handshake.
- For loads and stores, performs a single request/response transaction on the data-memory bus.
- Aligns and extends load data.
- Presents registered results plus a one-cycle lsu_valid pulse to write-back.
- Non-memory instructions pass through in one cycle.

---
 rtl/lsu_pkg.sv | 58 +++++
 rtl/lsu_unit_if.sv | 24 ++
 rtl/lsu_load_align.sv | 34 +++
 rtl/lsu_unit.sv | 171 +++++++++++++++++
 tb/tb_lsu_unit.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared state, access-size types and funct3 encodings for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_DONE     = 2'd3
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } lsu_size_e;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   // Unsupported funct3 codes fall back to a full-word access.
   function automatic lsu_size_e access_size(input logic [2:0] op, input logic is_store);
      lsu_size_e sz;
      sz = SZ_WORD;
      if (is_store) begin
         case (op)
            SB:      sz = SZ_BYTE;
            SH:      sz = SZ_HALF;
            SW:      sz = SZ_WORD;
            default: sz = SZ_WORD;
         endcase
      end else begin
         case (op)
            LB, LBU: sz = SZ_BYTE;
            LH, LHU: sz = SZ_HALF;
            LW:      sz = SZ_WORD;
            default: sz = SZ_WORD;
         endcase
      end
      return sz;
   endfunction

   function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] addr);
      logic mis;
      case (sz)
         SZ_HALF: mis = addr[0];
         SZ_WORD: mis = |addr;
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_unit_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
interface lsu_unit_if;

   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_we;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wmask;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;
   logic        mem_rsp_err;

   modport master (
      output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
   );

   modport slave (
      input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
      output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
   );

endinterface

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/halfword/word from a read beat and sign/zero-extends it.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  mem_op,
   output logic [31:0] result
);

   logic [1:0]  lane;
   logic [31:0] shifted;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      lane   = 2'b00;
      result = '0;
      // Low address bits below the natural alignment are dropped (force-aligned).
      case (mem_op)
         LB, LBU: lane = addr;
         LH, LHU: lane = {addr[1], 1'b0};
         default: lane = 2'b00;
      endcase
      shifted = rdata >> {lane, 3'b000};
      case (mem_op)
         LB:                         result = {{24{shifted[7]}}, shifted[7:0]};
         LBU:                        result = {24'b0, shifted[7:0]};
         LH:                         result = {{16{shifted[15]}}, shifted[15:0]};
         LHU:                        result = {16'b0, shifted[15:0]};
         LW, 3'b011, 3'b110, 3'b111: result = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_unit.sv
// Multi-cycle load/store stage between EXU and write-back.
// Optional: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of force-aligning.
module lsu_unit
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             exu_valid,
   output logic             lsu_ready,
   input  logic             mem_ren,
   input  logic             mem_wen,
   input  logic [2:0]       mem_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [WIDTH-1:0] store_data,
   input  logic             rd_wen_i,
   input  logic [4:0]       rd_addr_i,
   input  logic [1:0]       rd_sel_i,
   output logic             rd_wen,
   output logic [4:0]       rd_addr,
   output logic [1:0]       rd_input_sel,
   output logic [WIDTH-1:0] alu_result_o,
   output logic             lsu_valid,
   output logic [WIDTH-1:0] lsu_data,
   output logic             lsu_fault,
   lsu_unit_if.master       mem
);

   lsu_state_e       state_q, state_d;
   logic             store_q, store_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] store_data_q, store_data_d;
   logic [WIDTH-1:0] alu_result_q, alu_result_d;
   logic             rd_wen_q, rd_wen_d;
   logic [4:0]       rd_addr_q, rd_addr_d;
   logic [1:0]       rd_sel_q, rd_sel_d;
   logic [WIDTH-1:0] lsu_data_q, lsu_data_d;
   logic             lsu_fault_q, lsu_fault_d;

   logic [31:0]      load_word;
   logic [31:0]      req_wdata;
   logic [3:0]       req_wmask;
   logic             misalign_trap;

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign_trap = is_misaligned(access_size(mem_op, mem_wen & ~mem_ren), alu_result[1:0]);
`else
   assign misalign_trap = 1'b0;
`endif

   lsu_load_align u_load_align (
      .rdata  (mem.mem_rsp_rdata),
      .addr   (alu_result_q[1:0]),
      .mem_op (op_q),
      .result (load_word)
   );

   always_comb begin
      state_d      = state_q;
      store_d      = store_q;
      op_d         = op_q;
      store_data_d = store_data_q;
      alu_result_d = alu_result_q;
      rd_wen_d     = rd_wen_q;
      rd_addr_d    = rd_addr_q;
      rd_sel_d     = rd_sel_q;
      lsu_data_d   = lsu_data_q;
      lsu_fault_d  = lsu_fault_q;

      case (state_q)
         ST_IDLE: begin
            if (exu_valid) begin
               // Load wins when both enables are set.
               store_d      = mem_wen & ~mem_ren;
               op_d         = mem_op;
               store_data_d = store_data;
               alu_result_d = alu_result;
               rd_wen_d     = rd_wen_i;
               rd_addr_d    = rd_addr_i;
               rd_sel_d     = rd_sel_i;
               lsu_data_d   = '0;
               lsu_fault_d  = 1'b0;
               if ((mem_ren | mem_wen) && misalign_trap) begin
                  lsu_fault_d = 1'b1;
                  state_d     = ST_DONE;
               end else if (mem_ren | mem_wen) begin
                  state_d = ST_REQ;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_REQ: begin
            if (mem.mem_req_ready) state_d = ST_WAIT_RSP;
         end
         ST_WAIT_RSP: begin
            if (mem.mem_rsp_valid) begin
               lsu_data_d  = (mem.mem_rsp_err || store_q) ? '0 : load_word;
               lsu_fault_d = mem.mem_rsp_err;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         store_q      <= 1'b0;
         op_q         <= '0;
         store_data_q <= '0;
         alu_result_q <= '0;
         rd_wen_q     <= 1'b0;
         rd_addr_q    <= '0;
         rd_sel_q     <= '0;
         lsu_data_q   <= '0;
         lsu_fault_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         store_q      <= store_d;
         op_q         <= op_d;
         store_data_q <= store_data_d;
         alu_result_q <= alu_result_d;
         rd_wen_q     <= rd_wen_d;
         rd_addr_q    <= rd_addr_d;
         rd_sel_q     <= rd_sel_d;
         lsu_data_q   <= lsu_data_d;
         lsu_fault_q  <= lsu_fault_d;
      end
   end

   // Lanes derive from captured state only, so they stay stable while REQ waits for ready.
   always_comb begin
      req_wdata = store_data_q;
      req_wmask = 4'b1111;
      case (access_size(op_q, 1'b1))
         SZ_BYTE: begin
            req_wdata = {4{store_data_q[7:0]}};
            req_wmask = 4'b0001 << alu_result_q[1:0];
         end
         SZ_HALF: begin
            req_wdata = {2{store_data_q[15:0]}};
            req_wmask = 4'b0011 << {alu_result_q[1], 1'b0};
         end
         default: begin
            req_wdata = store_data_q;
            req_wmask = 4'b1111;
         end
      endcase
   end

   assign lsu_ready         = (state_q == ST_IDLE);
   assign lsu_valid         = (state_q == ST_DONE);
   assign lsu_data          = lsu_data_q;
   assign lsu_fault         = lsu_fault_q;
   assign alu_result_o      = alu_result_q;
   assign rd_wen            = rd_wen_q;
   assign rd_addr           = rd_addr_q;
   assign rd_input_sel      = rd_sel_q;

   assign mem.mem_req_valid = (state_q == ST_REQ);
   assign mem.mem_req_we    = store_q;
   assign mem.mem_req_addr  = {alu_result_q[31:2], 2'b00};
   assign mem.mem_req_wdata = req_wdata;
   assign mem.mem_req_wmask = store_q ? req_wmask : 4'b0000;

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: directed scenarios plus randomized traffic against a byte-lane model.
module tb_lsu_unit;

   logic        clk;
   logic        rst;
   logic        exu_valid;
   logic        lsu_ready;
   logic        mem_ren;
   logic        mem_wen;
   logic [2:0]  mem_op;
   logic [31:0] alu_result;
   logic [31:0] store_data;
   logic        rd_wen_i;
   logic [4:0]  rd_addr_i;
   logic [1:0]  rd_sel_i;
   logic        rd_wen;
   logic [4:0]  rd_addr;
   logic [1:0]  rd_input_sel;
   logic [31:0] alu_result_o;
   logic        lsu_valid;
   logic [31:0] lsu_data;
   logic        lsu_fault;

   lsu_unit_if mem_bus ();

   lsu_unit #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .exu_valid    (exu_valid),
      .lsu_ready    (lsu_ready),
      .mem_ren      (mem_ren),
      .mem_wen      (mem_wen),
      .mem_op       (mem_op),
      .alu_result   (alu_result),
      .store_data   (store_data),
      .rd_wen_i     (rd_wen_i),
      .rd_addr_i    (rd_addr_i),
      .rd_sel_i     (rd_sel_i),
      .rd_wen       (rd_wen),
      .rd_addr      (rd_addr),
      .rd_input_sel (rd_input_sel),
      .alu_result_o (alu_result_o),
      .lsu_valid    (lsu_valid),
      .lsu_data     (lsu_data),
      .lsu_fault    (lsu_fault),
      .mem          (mem_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run = 0;
   int failures  = 0;

   // Observations of the most recent instruction driven by run_instr.
   bit          obs_req;
   logic        obs_we;
   logic [31:0] obs_addr;
   logic [31:0] obs_wdata;
   logic [3:0]  obs_wmask;
   bit          obs_unstable;
   int          obs_req_cycles;
   int          obs_lat;
   int          obs_rsp_k;
   int          obs_pulses;
   bit          obs_timeout;
   logic [31:0] obs_data;
   logic        obs_fault;
   logic [31:0] obs_alu;
   logic        obs_rd_wen;
   logic [4:0]  obs_rd_addr;
   logic [1:0]  obs_rd_sel;

   // ---------------- reference model ----------------
   function automatic int model_size(input logic [2:0] op, input bit is_store);
      if (is_store) return (op == 3'd0) ? 1 : (op == 3'd1) ? 2 : 4;
      if (op == 3'd0 || op == 3'd4) return 1;
      if (op == 3'd1 || op == 3'd5) return 2;
      return 4;
   endfunction

   function automatic int model_lane(input int sz, input logic [31:0] addr);
      int a;
      a = int'(addr[1:0]);
      return (a / sz) * sz;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                              input logic [31:0] rdata);
      int          sz;
      logic [31:0] v;
      sz = model_size(op, 1'b0);
      v  = rdata >> (8 * model_lane(sz, addr));
      if (sz == 1) v = op[2] ? (v & 32'h0000_00FF) : 32'($signed(v[7:0]));
      if (sz == 2) v = op[2] ? (v & 32'h0000_FFFF) : 32'($signed(v[15:0]));
      return v;
   endfunction

   function automatic logic [3:0] model_mask(input logic [2:0] op, input logic [31:0] addr);
      int         sz, lane;
      logic [3:0] m;
      sz   = model_size(op, 1'b1);
      lane = model_lane(sz, addr);
      for (int i = 0; i < 4; i++) m[i] = (i >= lane) && (i < lane + sz);
      return m;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] sd);
      int          sz;
      logic [31:0] w;
      sz = model_size(op, 1'b1);
      for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
      return w;
   endfunction

   function automatic bit model_trap(input bit ren, input bit wen, input logic [2:0] op,
                                     input logic [31:0] addr);
      int sz;
      sz = model_size(op, wen && !ren);
`ifdef LSU_MISALIGN_TRAP_EN
      return (ren || wen) && ((int'(addr[1:0]) % sz) != 0);
`else
      return (sz < 0);
`endif
   endfunction

   // ---------------- drive one instruction and act as the memory slave ----------------
   task automatic run_instr(input bit ren, input bit wen, input logic [2:0] op,
                            input logic [31:0] addr, input logic [31:0] sd,
                            input int rdy_dly, input int rsp_dly,
                            input logic [31:0] rdata, input bit err,
                            input logic rdw, input logic [4:0] rda, input logic [1:0] rds);
      int rdy_cnt;
      int rsp_cnt;
      bit waiting;
      int first_v;
      obs_req = 0; obs_unstable = 0; obs_req_cycles = 0; obs_lat = -1; obs_rsp_k = -1;
      obs_pulses = 0; obs_timeout = 0; obs_we = 1'bx; obs_addr = 'x; obs_wdata = 'x;
      obs_wmask = 'x; obs_data = 'x; obs_fault = 1'bx;
      rdy_cnt = 0; rsp_cnt = 0; waiting = 0; first_v = -1;

      @(negedge clk);
      exu_valid = 1'b1; mem_ren = ren; mem_wen = wen; mem_op = op; alu_result = addr;
      store_data = sd; rd_wen_i = rdw; rd_addr_i = rda; rd_sel_i = rds;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (k == 1) begin
            exu_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
            alu_result = $urandom; store_data = $urandom;
         end
         if (mem_bus.mem_rsp_valid) mem_bus.mem_rsp_valid = 1'b0;
         if (lsu_valid) begin
            obs_pulses++;
            if (first_v < 0) begin
               first_v = k; obs_lat = k; obs_data = lsu_data; obs_fault = lsu_fault;
               obs_alu = alu_result_o; obs_rd_wen = rd_wen; obs_rd_addr = rd_addr;
               obs_rd_sel = rd_input_sel;
            end
         end
         if (mem_bus.mem_req_valid) begin
            obs_req_cycles++;
            if (!obs_req) begin
               obs_req = 1; obs_we = mem_bus.mem_req_we; obs_addr = mem_bus.mem_req_addr;
               obs_wdata = mem_bus.mem_req_wdata; obs_wmask = mem_bus.mem_req_wmask;
            end else if ({obs_we, obs_addr, obs_wdata, obs_wmask} !==
                         {mem_bus.mem_req_we, mem_bus.mem_req_addr,
                          mem_bus.mem_req_wdata, mem_bus.mem_req_wmask}) begin
               obs_unstable = 1;
            end
            if (rdy_cnt >= rdy_dly) mem_bus.mem_req_ready = 1'b1;
            rdy_cnt++;
         end else if (mem_bus.mem_req_ready) begin
            mem_bus.mem_req_ready = 1'b0;
            waiting = 1; rsp_cnt = 0;
         end
         if (waiting) begin
            if (rsp_cnt >= rsp_dly) begin
               mem_bus.mem_rsp_valid = 1'b1; mem_bus.mem_rsp_rdata = rdata;
               mem_bus.mem_rsp_err = err; obs_rsp_k = k; waiting = 0;
            end else begin
               rsp_cnt++;
            end
         end
         if (first_v >= 0 && k >= first_v + 3) break;
      end
      if (first_v < 0) obs_timeout = 1;
      mem_bus.mem_req_ready = 1'b0; mem_bus.mem_rsp_valid = 1'b0; mem_bus.mem_rsp_err = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      #3;
      tests_run++;
      if ({lsu_ready, lsu_valid, mem_bus.mem_req_valid, lsu_fault, rd_wen, mem_bus.mem_req_we,
           mem_bus.mem_req_wmask} !== 10'b10_0000_0000) begin
         failures++;
         $display("FAIL reset_ctrl: got %b expected %b", {lsu_ready, lsu_valid,
                  mem_bus.mem_req_valid, lsu_fault, rd_wen, mem_bus.mem_req_we,
                  mem_bus.mem_req_wmask}, 10'b10_0000_0000);
      end
      tests_run++;
      if ({lsu_data, alu_result_o, rd_addr, rd_input_sel} !== 71'd0) begin
         failures++;
         $display("FAIL reset_data: got data=%h alu=%h rd=%h sel=%h expected zeros",
                  lsu_data, alu_result_o, rd_addr, rd_input_sel);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_passthrough();
      run_instr(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'hFFFF_FFFF, 0, 0, 32'h0, 1'b0,
                1'b1, 5'd7, 2'd2);
      tests_run++;
      if (obs_lat !== 1) begin
         failures++; $display("FAIL add_latency: got %0d expected 1", obs_lat);
      end
      tests_run++;
      if (obs_req !== 1'b0) begin
         failures++; $display("FAIL add_no_req: got %0d expected 0", obs_req);
      end
      tests_run++;
      if ({obs_alu, obs_rd_wen, obs_rd_addr, obs_rd_sel, obs_data, obs_fault} !==
          {32'h0000_1234, 1'b1, 5'd7, 2'd2, 32'h0, 1'b0}) begin
         failures++;
         $display("FAIL add_results: got alu=%h wen=%b rd=%0d sel=%0d data=%h fault=%b expected alu=00001234 wen=1 rd=7 sel=2 data=0 fault=0",
                  obs_alu, obs_rd_wen, obs_rd_addr, obs_rd_sel, obs_data, obs_fault);
      end
      tests_run++;
      if (obs_pulses !== 1) begin
         failures++; $display("FAIL add_pulses: got %0d expected 1", obs_pulses);
      end
   endtask

   task automatic test_load_byte();
      run_instr(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 0, 0, 32'h80FF_7F01, 1'b0,
                1'b1, 5'd3, 2'd1);
      tests_run++;
      if (obs_data !== 32'hFFFF_FF80) begin
         failures++; $display("FAIL lb_data: got %h expected ffffff80", obs_data);
      end
      tests_run++;
      if (obs_addr !== 32'h8000_0000 || obs_we !== 1'b0) begin
         failures++; $display("FAIL lb_req: got addr=%h we=%b expected addr=80000000 we=0",
                              obs_addr, obs_we);
      end
      tests_run++;
      if (obs_lat !== obs_rsp_k + 1) begin
         failures++; $display("FAIL lb_latency: got %0d expected %0d", obs_lat, obs_rsp_k + 1);
      end
      run_instr(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 1, 2, 32'h80FF_7F01, 1'b0,
                1'b1, 5'd4, 2'd1);
      tests_run++;
      if (obs_data !== 32'h0000_0080) begin
         failures++; $display("FAIL lbu_data: got %h expected 00000080", obs_data);
      end
   endtask

   task automatic test_store_half();
      run_instr(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'hABCD_1234, 3, 1, 32'h0, 1'b0,
                1'b0, 5'd0, 2'd0);
      tests_run++;
      if ({obs_we, obs_wmask, obs_wdata, obs_addr} !== {1'b1, 4'b1100, 32'h1234_1234, 32'h8000_0000}) begin
         failures++;
         $display("FAIL sh_req: got we=%b mask=%b wdata=%h addr=%h expected we=1 mask=1100 wdata=12341234 addr=80000000",
                  obs_we, obs_wmask, obs_wdata, obs_addr);
      end
      tests_run++;
      if (obs_unstable !== 1'b0 || obs_req_cycles !== 4) begin
         failures++; $display("FAIL sh_stable: got unstable=%0d req_cycles=%0d expected 0 and 4",
                              obs_unstable, obs_req_cycles);
      end
      tests_run++;
      if ({obs_data, obs_fault} !== 33'd0) begin
         failures++; $display("FAIL sh_result: got data=%h fault=%b expected 0/0", obs_data, obs_fault);
      end
   endtask

   task automatic test_load_err();
      run_instr(1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0, 0, 1, 32'hDEAD_BEEF, 1'b1,
                1'b1, 5'd9, 2'd1);
      tests_run++;
      if ({obs_fault, obs_data} !== {1'b1, 32'h0}) begin
         failures++; $display("FAIL lw_err: got fault=%b data=%h expected fault=1 data=0",
                              obs_fault, obs_data);
      end
      tests_run++;
      if (obs_pulses !== 1) begin
         failures++; $display("FAIL lw_err_pulses: got %0d expected 1", obs_pulses);
      end
   endtask

   task automatic test_reset_in_wait();
      int pulses;
      int busy;
      pulses = 0; busy = 0;
      @(negedge clk);
      exu_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; mem_op = 3'b010;
      alu_result = 32'h8000_0010;
      @(negedge clk);
      exu_valid = 1'b0; mem_ren = 1'b0;
      mem_bus.mem_req_ready = 1'b1;
      @(negedge clk);
      mem_bus.mem_req_ready = 1'b0;
      tests_run++;
      if ({lsu_ready, mem_bus.mem_req_valid} !== 2'b00) begin
         failures++; $display("FAIL rst_wait_state: got ready=%b req=%b expected 0/0",
                              lsu_ready, mem_bus.mem_req_valid);
      end
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if ({lsu_ready, mem_bus.mem_req_valid, lsu_valid} !== 3'b100) begin
         failures++; $display("FAIL rst_async: got %b expected 100",
                              {lsu_ready, mem_bus.mem_req_valid, lsu_valid});
      end
      @(negedge clk);
      rst = 1'b0;
      mem_bus.mem_rsp_valid = 1'b1; mem_bus.mem_rsp_rdata = 32'h1111_2222;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         mem_bus.mem_rsp_valid = 1'b0;
         if (lsu_valid) pulses++;
         if (!lsu_ready) busy++;
      end
      tests_run++;
      if (pulses !== 0 || busy !== 0) begin
         failures++; $display("FAIL rst_late_rsp: got pulses=%0d busy=%0d expected 0/0", pulses, busy);
      end
   endtask

   task automatic test_misalign();
      run_instr(1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'h0, 0, 0, 32'hCAFE_F00D, 1'b0,
                1'b1, 5'd5, 2'd1);
`ifdef LSU_MISALIGN_TRAP_EN
      tests_run++;
      if ({obs_req, obs_lat, obs_fault, obs_data} !== {1'b0, 32'd1, 1'b1, 32'h0}) begin
         failures++; $display("FAIL misalign_trap: got req=%0d lat=%0d fault=%b data=%h expected 0/1/1/0",
                              obs_req, obs_lat, obs_fault, obs_data);
      end
`else
      tests_run++;
      if ({obs_req, obs_addr, obs_fault, obs_data} !== {1'b1, 32'h8000_0000, 1'b0, 32'hCAFE_F00D}) begin
         failures++; $display("FAIL misalign_force: got req=%0d addr=%h fault=%b data=%h expected 1/80000000/0/cafef00d",
                              obs_req, obs_addr, obs_fault, obs_data);
      end
`endif
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         bit          ren, wen, err, st, trap, exp_req, rdw;
         logic [2:0]  op;
         logic [31:0] addr, sd, rdata, exp_data;
         logic [4:0]  rda;
         logic [1:0]  rds;
         int          rdy, rsp, exp_lat;
         ren = ($urandom_range(0, 2) != 0) ? $urandom_range(0, 1) : 1'b0;
         wen = $urandom_range(0, 1);
         op = 3'($urandom_range(0, 7)); addr = $urandom; sd = $urandom; rdata = $urandom;
         err = ($urandom_range(0, 7) == 0); rdy = $urandom_range(0, 3); rsp = $urandom_range(0, 3);
         rdw = $urandom_range(0, 1); rda = 5'($urandom); rds = 2'($urandom);
         run_instr(ren, wen, op, addr, sd, rdy, rsp, rdata, err, rdw, rda, rds);

         st       = wen && !ren;
         trap     = model_trap(ren, wen, op, addr);
         exp_req  = (ren || wen) && !trap;
         exp_lat  = exp_req ? obs_rsp_k + 1 : 1;
         exp_data = (exp_req && ren && !err) ? model_load(op, addr, rdata) : 32'h0;

         tests_run++;
         if (obs_timeout || obs_pulses !== 1 || obs_req !== exp_req || obs_lat !== exp_lat) begin
            failures++;
            $display("FAIL rnd_flow[%0d]: got timeout=%0d pulses=%0d req=%0d lat=%0d expected 0/1/%0d/%0d",
                     n, obs_timeout, obs_pulses, obs_req, obs_lat, exp_req, exp_lat);
         end
         tests_run++;
         if ({obs_data, obs_fault} !== {exp_data, (exp_req && err) || trap}) begin
            failures++;
            $display("FAIL rnd_result[%0d]: op=%0d addr=%h got data=%h fault=%b expected data=%h fault=%b",
                     n, op, addr, obs_data, obs_fault, exp_data, (exp_req && err) || trap);
         end
         tests_run++;
         if ({obs_alu, obs_rd_wen, obs_rd_addr, obs_rd_sel} !== {addr, rdw, rda, rds}) begin
            failures++;
            $display("FAIL rnd_wb[%0d]: got alu=%h wen=%b rd=%0d sel=%0d expected alu=%h wen=%b rd=%0d sel=%0d",
                     n, obs_alu, obs_rd_wen, obs_rd_addr, obs_rd_sel, addr, rdw, rda, rds);
         end
         if (exp_req) begin
            tests_run++;
            if ({obs_we, obs_addr, obs_unstable} !== {st, addr & 32'hFFFF_FFFC, 1'b0} ||
                obs_req_cycles !== rdy + 1) begin
               failures++;
               $display("FAIL rnd_req[%0d]: got we=%b addr=%h unstable=%0d cycles=%0d expected we=%b addr=%h unstable=0 cycles=%0d",
                        n, obs_we, obs_addr, obs_unstable, obs_req_cycles, st,
                        addr & 32'hFFFF_FFFC, rdy + 1);
            end
         end
         if (exp_req && st) begin
            tests_run++;
            if ({obs_wmask, obs_wdata} !== {model_mask(op, addr), model_wdata(op, sd)}) begin
               failures++;
               $display("FAIL rnd_store[%0d]: op=%0d addr=%h got mask=%b wdata=%h expected mask=%b wdata=%h",
                        n, op, addr, obs_wmask, obs_wdata, model_mask(op, addr), model_wdata(op, sd));
            end
         end
      end
   endtask

   initial begin
      exu_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; mem_op = 3'b000;
      alu_result = '0; store_data = '0; rd_wen_i = 1'b0; rd_addr_i = '0; rd_sel_i = '0;
      mem_bus.mem_req_ready = 1'b0; mem_bus.mem_rsp_valid = 1'b0;
      mem_bus.mem_rsp_rdata = '0; mem_bus.mem_rsp_err = 1'b0;

      test_reset();
      test_passthrough();
      test_load_byte();
      test_store_half();
      test_load_err();
      test_reset_in_wait();
      test_misalign();
      test_random();

      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
